// File: rtl/spi_master_param_if.sv
// ---------------------------------------------------------------------------
// spi_master_param_if
//
// Bundles the controller handshake and the SPI pins of spi_master_param.
//
// Parameters:
//   DW   - bits per word
//   NRX  - number of RX words per transaction (0 = TX-only)
//
// Signals:
//   start   - transaction request from the local controller
//   txdata  - word to transmit, latched when start is accepted
//   rxsig   - serial data from the slave (MISO)
//   txsig   - serial data to the slave (MOSI)
//   spiclk  - SPI clock
//   cs_n    - chip select, active low
//   busy    - transaction in progress
//   done    - one-cycle end-of-transaction pulse
//   rxdata  - received words, word 0 in the lowest DW bits (1 bit, tied 0,
//             when NRX is 0)
//
// Modports:
//   master - the SPI master's view
//   slave  - the environment's view (controller plus external SPI slave)
// ---------------------------------------------------------------------------
interface spi_master_param_if #(
    parameter int DW  = 8,
    parameter int NRX = 2
);
    localparam int RXW = (NRX == 0) ? 1 : NRX * DW;

    logic           start;
    logic [DW-1:0]  txdata;
    logic           rxsig;
    logic           txsig;
    logic           spiclk;
    logic           cs_n;
    logic           busy;
    logic           done;
    logic [RXW-1:0] rxdata;

    modport master (
        input  start,
        input  txdata,
        input  rxsig,
        output txsig,
        output spiclk,
        output cs_n,
        output busy,
        output done,
        output rxdata
    );

    modport slave (
        output start,
        output txdata,
        output rxsig,
        input  txsig,
        input  spiclk,
        input  cs_n,
        input  busy,
        input  done,
        input  rxdata
    );
endinterface

// File: rtl/spi_master_param.sv
// ---------------------------------------------------------------------------
// spi_master_param
//
// Parametrised SPI master. One accepted start runs a transaction made of one
// TX word shifted out on txsig, followed by NRX RX words shifted in from
// rxsig. Chip select is held low for the whole transaction, and a single
// FIN cycle raises done before the block returns to IDLE.
//
// Parameters:
//   DW        - bits per word (>= 2)
//   NRX       - RX words after the TX word (0..8, 0 = TX-only)
//   CLKDIV    - clk cycles per spiclk half-period (>= 2)
//   CPOL      - idle level of spiclk
//   LSB_FIRST - 0: MSB first, 1: LSB first (TX and RX)
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - spi_master_param_if.master (start/txdata/rxsig in,
//          txsig/spiclk/cs_n/busy/done/rxdata out)
// ---------------------------------------------------------------------------
module spi_master_param #(
    parameter int DW        = 8,
    parameter int NRX       = 2,
    parameter int CLKDIV    = 125,
    parameter int CPOL      = 0,
    parameter int LSB_FIRST = 0
) (
    input  logic               clk,
    input  logic               rst,
    spi_master_param_if.master bus
);

    localparam int DIVW       = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int TOTAL_BITS = (1 + NRX) * DW;
    localparam int BCW        = $clog2(TOTAL_BITS);

    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLKDIV - 1);
    localparam logic [BCW-1:0]  TX_LAST  = BCW'(DW - 1);
    localparam logic [BCW-1:0]  RX_LAST  = BCW'((NRX > 0) ? NRX * DW - 1 : 0);
    localparam logic            IDLE_LVL = (CPOL != 0);

    typedef enum logic [1:0] {
        IDLE,
        TX,
        RX,
        FIN
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [DIVW-1:0]  div_cnt;
    logic             phase;
    logic [BCW-1:0]   bit_cnt;
    logic [DW-1:0]    tx_sh;

    logic             active;
    logic             sample;
    logic             bit_end;
    logic             last_bit;

    logic             txsig_c;
    logic             spiclk_c;
    logic             cs_n_c;
    logic             busy_c;
    logic             done_c;

    // phase 0 is the first half of a bit (spiclk at its idle level), phase 1
    // the second half. The edge that ends phase 0 is the leading spiclk edge,
    // where the slave's data is captured; the edge that ends phase 1 closes
    // the bit.
    assign active  = (state == TX) || (state == RX);
    assign sample  = active && !phase && (div_cnt == DIV_LAST);
    assign bit_end = active &&  phase && (div_cnt == DIV_LAST);

    // Last bit of the current phase of the transaction
    always_comb begin
        last_bit = 1'b0;
        if (state == TX) begin
            last_bit = (bit_cnt == TX_LAST);
        end else if (state == RX) begin
            last_bit = (bit_cnt == RX_LAST);
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start is only looked at in IDLE, so requests made
    // while a transaction is in flight are simply dropped
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = TX;
                end
            end
            TX: begin
                if (bit_end && last_bit) begin
                    state_next = (NRX > 0) ? RX : FIN;
                end
            end
            RX: begin
                if (bit_end && last_bit) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output decode; every pin is a pure function of registered state, so
    // txsig can only move when tx_sh shifts, i.e. at a bit boundary
    always_comb begin
        txsig_c  = 1'b0;
        spiclk_c = IDLE_LVL;
        cs_n_c   = 1'b1;
        busy_c   = 1'b0;
        done_c   = 1'b0;
        case (state)
            TX: begin
                cs_n_c   = 1'b0;
                busy_c   = 1'b1;
                spiclk_c = IDLE_LVL ^ phase;
                txsig_c  = (LSB_FIRST != 0) ? tx_sh[0] : tx_sh[DW-1];
            end
            RX: begin
                cs_n_c   = 1'b0;
                busy_c   = 1'b1;
                spiclk_c = IDLE_LVL ^ phase;
            end
            FIN: begin
                done_c   = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.txsig  = txsig_c;
    assign bus.spiclk = spiclk_c;
    assign bus.cs_n   = cs_n_c;
    assign bus.busy   = busy_c;
    assign bus.done   = done_c;

    // Divider, half-bit phase, bit counter and TX shift register. The TX
    // word is captured on the accepting edge, so later txdata changes cannot
    // reach the transaction in flight. Counters restart on every state
    // entry because IDLE/FIN clear them and a TX->RX hand-over happens
    // exactly when the bit counter reaches its last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            phase   <= 1'b0;
            bit_cnt <= '0;
            tx_sh   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    div_cnt <= '0;
                    phase   <= 1'b0;
                    bit_cnt <= '0;
                    if (bus.start) begin
                        tx_sh <= bus.txdata;
                    end
                end
                TX, RX: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        phase   <= ~phase;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                    if (bit_end) begin
                        bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
                        if (state == TX) begin
                            tx_sh <= (LSB_FIRST != 0) ? {1'b0, tx_sh[DW-1:1]}
                                                      : {tx_sh[DW-2:0], 1'b0};
                        end
                    end
                end
                default: begin
                    div_cnt <= '0;
                    phase   <= 1'b0;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

    generate
        if (NRX > 0) begin : g_rx
            localparam int WIW = $clog2(NRX + 1);
            localparam int WBW = $clog2(DW);
            localparam logic [WBW-1:0] WB_LAST = WBW'(DW - 1);

            logic [DW-1:0]     rx_sh;
            logic [DW-1:0]     rx_shifted;
            logic [WIW-1:0]    word_idx;
            logic [WBW-1:0]    word_bit;
            logic [NRX*DW-1:0] rx_q;

            // Shift register contents after taking the current rxsig bit,
            // in the configured bit order
            always_comb begin
                rx_shifted = (LSB_FIRST != 0) ? {bus.rxsig, rx_sh[DW-1:1]}
                                              : {rx_sh[DW-2:0], bus.rxsig};
            end

            // RX capture. A completed word is written straight from
            // rx_shifted so rxdata word k updates on the same edge that
            // takes its last bit; words not yet reached keep the values
            // from the previous transaction.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rx_sh    <= '0;
                    word_idx <= '0;
                    word_bit <= '0;
                    rx_q     <= '0;
                end else if (state == RX) begin
                    if (sample) begin
                        rx_sh <= rx_shifted;
                        if (word_bit == WB_LAST) begin
                            rx_q[int'(word_idx)*DW +: DW] <= rx_shifted;
                            word_bit <= '0;
                            word_idx <= word_idx + 1'b1;
                        end else begin
                            word_bit <= word_bit + 1'b1;
                        end
                    end
                end else begin
                    word_idx <= '0;
                    word_bit <= '0;
                end
            end

            assign bus.rxdata = rx_q;
        end else begin : g_norx
            assign bus.rxdata = 1'b0;
        end
    endgenerate

endmodule
